// File: rtl/acc_apb_master_if.sv
// acc_apb_master_if: APB bus plus the source-word handshake used by acc_apb_master.
interface acc_apb_master_if;
   logic [12:0] PADDR;
   logic        PSEL;
   logic        PENABLE;
   logic        PWRITE;
   logic [31:0] PWDATA;
   logic [31:0] PRDATA;
   logic        PREADY;
   logic        PSLVERR;
   logic [31:0] src_data;
   logic        src_valid;
   logic        src_ready;
   modport master (
      output PADDR, PSEL, PENABLE, PWRITE, PWDATA, src_ready,
      input  PRDATA, PREADY, PSLVERR, src_data, src_valid
   );
   modport slave (
      input  PADDR, PSEL, PENABLE, PWRITE, PWDATA, src_ready,
      output PRDATA, PREADY, PSLVERR, src_data, src_valid
   );
endinterface

// File: rtl/acc_apb_master.sv
// acc_apb_master: APB master sequencing enable, A/X matrix loads, a wait gap, result reads and disable.
module acc_apb_master #(
   parameter int A_WORDS  = 3,
   parameter int X_WORDS  = 196,
   parameter int R_NUM    = 784,
   parameter int WAIT_CYC = 100
) (
   input  logic             HCLK,
   input  logic             HRESET,
   input  logic             start,
   acc_apb_master_if.master bus,
   output logic [19:0]      res_data,
   output logic             res_valid,
   output logic             busy,
   output logic             done,
   output logic             err
);
   typedef enum logic [2:0] {IDLE, EN_ON, LOAD_A, LOAD_X, WAIT, READ, EN_OFF} state_t;
   typedef enum logic [1:0] {P_IDLE, P_SETUP, P_ACCESS} phase_t;
   // Successors skip any state whose parameter count is zero.
   localparam state_t AFTER_WAIT   = R_NUM    > 0 ? READ   : EN_OFF;
   localparam state_t AFTER_LOAD_X = WAIT_CYC > 0 ? WAIT   : AFTER_WAIT;
   localparam state_t AFTER_LOAD_A = X_WORDS  > 0 ? LOAD_X : AFTER_LOAD_X;
   localparam state_t AFTER_EN_ON  = A_WORDS  > 0 ? LOAD_A : AFTER_LOAD_A;
   state_t      state, state_n, nxt;
   phase_t      phase, phase_n;
   logic [15:0] cnt, cnt_n, lim;
   logic [12:0] paddr, paddr_n;
   logic [31:0] pwdata, pwdata_n;
   logic        pwrite, pwrite_n;
   logic [19:0] res_data_n;
   logic        res_valid_n, done_n, err_n, last, load, ready;
   assign lim = state == LOAD_A ? 16'(A_WORDS) : state == LOAD_X ? 16'(X_WORDS) :
                state == WAIT ? 16'(WAIT_CYC) : state == READ ? 16'(R_NUM) : 16'd1;
   assign nxt = state == EN_ON ? AFTER_EN_ON : state == LOAD_A ? AFTER_LOAD_A :
                state == LOAD_X ? AFTER_LOAD_X : state == WAIT ? AFTER_WAIT :
                state == READ ? EN_OFF : state == EN_OFF ? IDLE : EN_ON;
   assign last = cnt + 16'd1 == lim;
   assign load = state == LOAD_A || state == LOAD_X;
   assign busy = state != IDLE;
   assign bus.PSEL = phase != P_IDLE;
   assign bus.PENABLE = phase == P_ACCESS;
   assign bus.PADDR = paddr;
   assign bus.PWDATA = pwdata;
   assign bus.PWRITE = pwrite;
   assign bus.src_ready = ready;
   always_comb begin
      state_n = state;
      phase_n = phase;
      cnt_n = cnt;
      paddr_n = paddr;
      pwdata_n = pwdata;
      pwrite_n = pwrite;
      res_data_n = res_data;
      res_valid_n = 1'b0;
      done_n = 1'b0;
      err_n = err;
      ready = 1'b0;
      if (state == IDLE) begin
         if (start) begin
            state_n = EN_ON;
            err_n = 1'b0;
         end
      end else if (state == WAIT) begin
         cnt_n = last ? 16'd0 : cnt + 16'd1;
         state_n = last ? nxt : state;
      end else if (phase == P_SETUP) begin
         phase_n = P_ACCESS;
      end else if (phase == P_ACCESS) begin
         if (bus.PREADY) begin
            phase_n = P_IDLE;
            cnt_n = last ? 16'd0 : cnt + 16'd1;
            state_n = last ? nxt : state;
            err_n = err | bus.PSLVERR;
            done_n = state == EN_OFF;
            res_valid_n = state == READ;
            res_data_n = state == READ ? bus.PRDATA[19:0] : res_data;
         end
      end else if (!load || bus.src_valid) begin
         // Bus-idle phase: launch the next transfer; loads wait for a source word.
         phase_n = P_SETUP;
         ready = load;
         pwrite_n = state != READ;
         paddr_n = state == READ ? 13'({cnt + 16'd1, 2'b00}) : state == LOAD_A ? 13'd1 :
                   state == LOAD_X ? 13'd2 : 13'h1FFF;
         pwdata_n = load ? bus.src_data : state == EN_ON ? 32'd1 : 32'd0;
      end
   end
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state <= IDLE;
         phase <= P_IDLE;
         cnt <= '0;
         paddr <= '0;
         pwdata <= '0;
         pwrite <= 1'b0;
         res_data <= '0;
         res_valid <= 1'b0;
         done <= 1'b0;
         err <= 1'b0;
      end else begin
         state <= state_n;
         phase <= phase_n;
         cnt <= cnt_n;
         paddr <= paddr_n;
         pwdata <= pwdata_n;
         pwrite <= pwrite_n;
         res_data <= res_data_n;
         res_valid <= res_valid_n;
         done <= done_n;
         err <= err_n;
      end
   end
endmodule

// File: tb/tb_acc_apb_master.sv
// tb_acc_apb_master: directed runs of acc_apb_master against a transfer-list model of a whole run.
module tb_acc_apb_master;
   localparam int A = 3, X = 196, R = 784, W = 100;
   typedef struct packed {logic [12:0] addr; logic wr; logic [31:0] data;} xfer_t;
   logic        clk = 1'b0;
   logic        HRESET, start;
   logic [19:0] res_data;
   logic        res_valid, busy, done, err;
   acc_apb_master_if bus();
   acc_apb_master dut (.HCLK(clk), .HRESET(HRESET), .start(start), .bus(bus),
      .res_data(res_data), .res_valid(res_valid), .busy(busy), .done(done), .err(err));
   always #5 clk = ~clk;
   int nchk = 0, nerr = 0;
   int stall_at = 0, stall_n = 0, err_k = 0;
   bit src_en = 1'b1;
   logic [31:0] words [A+X];
   int widx = 0;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask
   initial foreach (words[i]) words[i] = $urandom;
   // Slave and source: drive inputs shortly after each rising edge.
   initial begin
      int xn = 0, acc = 0, st;
      bus.PREADY = 0; bus.PSLVERR = 0; bus.PRDATA = 0; bus.src_valid = 0; bus.src_data = 0;
      forever begin
         @(posedge clk);
         #1;
         if (!busy) xn = 0;
         if (bus.PSEL && bus.PENABLE) begin
            st = (xn + 1 == stall_at) ? stall_n : 0;
            bus.PREADY = (acc == st);
            bus.PSLVERR = err_k != 0 && !bus.PWRITE && bus.PADDR == 13'(4 * err_k);
            bus.PRDATA = bus.PADDR == 13'd4 ? 32'hFFFABCDE : {12'h5A5, 20'(bus.PADDR) * 20'd37 ^ 20'h3C3C3};
            if (bus.PREADY) begin xn++; acc = 0; end else acc++;
         end else begin
            bus.PREADY = 0; bus.PSLVERR = 1; bus.PRDATA = 32'hDEAD0000; acc = 0;
         end
         bus.src_valid = src_en;
         bus.src_data = widx < A + X ? words[widx] : 32'hBAD0BAD0;
      end
   end
   // Model and compare: expected transfer list per run, checked every cycle at the falling edge.
   xfer_t q[$];
   int nx = 0, rv_cnt = 0, sr_cnt = 0, len6 = 0, acc_len = 0, cyc = 0, lastx = 0;
   logic [19:0] first_res = '0, rd_exp = '0;
   bit busy_exp = 0, err_exp = 0, done_exp = 0, rv_exp = 0, rst_prev = 0;
   bit prev_psel = 0, prev_pen = 0, prev_rdy = 0, prev_sr = 0;
   logic [12:0] s_addr; logic s_wr; logic [31:0] s_data;
   initial forever begin
      xfer_t e;
      bit b, comp;
      @(negedge clk);
      cyc++;
      comp = 0;
      if (rst_prev) begin
         chk("rst_psel", bus.PSEL, 0); chk("rst_penable", bus.PENABLE, 0); chk("rst_pwrite", bus.PWRITE, 0);
         chk("rst_paddr", bus.PADDR, 0); chk("rst_pwdata", bus.PWDATA, 0); chk("rst_src_ready", bus.src_ready, 0);
         chk("rst_res_data", res_data, 0); chk("rst_res_valid", res_valid, 0); chk("rst_busy", busy, 0);
         chk("rst_done", done, 0); chk("rst_err", err, 0);
      end else begin
         chk("busy", busy, busy_exp); chk("err", err, err_exp); chk("done", done, done_exp);
         chk("res_valid", res_valid, rv_exp);
         if (rv_exp) begin
            chk("res_data", res_data, rd_exp);
            if (rv_cnt == 1) first_res = res_data;
         end
         if (!busy_exp) chk("psel_idle", bus.PSEL, 0);
         if (bus.src_ready) chk("ready_needs_valid", bus.src_valid, 1);
         if (bus.PSEL && !bus.PENABLE) begin
            chk("setup_after_idle", prev_psel, 0);
            if (q.size() == 0) chk("extra_transfer", 1, 0);
            else begin
               e = q.pop_front();
               chk("paddr", bus.PADDR, e.addr); chk("pwrite", bus.PWRITE, e.wr); chk("pwdata", bus.PWDATA, e.data);
               if (e.wr && (e.addr == 13'd1 || e.addr == 13'd2)) chk("ready_before_setup", prev_sr, 1);
               if (!e.wr && e.addr == 13'd4) chk("wait_gap", (cyc - lastx - 1) >= W, 1);
            end
            s_addr = bus.PADDR; s_wr = bus.PWRITE; s_data = bus.PWDATA; acc_len = 0;
         end
         if (bus.PENABLE) begin
            chk("penable_psel", bus.PSEL, 1);
            chk("stable_addr", bus.PADDR, s_addr); chk("stable_wr", bus.PWRITE, s_wr); chk("stable_data", bus.PWDATA, s_data);
            acc_len++;
         end
         if (prev_psel && !prev_pen) chk("access_follows_setup", bus.PENABLE, 1);
         if (prev_pen && !prev_rdy) chk("access_held", bus.PENABLE, 1);
         if (prev_pen && prev_rdy) chk("idle_after_completion", bus.PSEL, 0);
         comp = bus.PSEL && bus.PENABLE && bus.PREADY && !HRESET;
      end
      b = busy_exp;
      rv_exp = 0; done_exp = 0;
      if (HRESET) begin
         rst_prev = 1; busy_exp = 0; err_exp = 0; q.delete();
      end else begin
         rst_prev = 0;
         if (comp) begin
            nx++;
            chk("access_len", acc_len, (nx == stall_at) ? stall_n + 1 : 1);
            if (nx == 6) len6 = acc_len;
            if (bus.PSLVERR) err_exp = 1;
            if (!bus.PWRITE) begin rv_exp = 1; rd_exp = bus.PRDATA[19:0]; rv_cnt++; end
            if (bus.PADDR == 13'd2) lastx = cyc;
            if (q.size() == 0) begin done_exp = 1; busy_exp = 0; end
         end
         if (bus.src_ready) begin sr_cnt++; widx++; end
         if (start && !b) begin
            busy_exp = 1; err_exp = 0; nx = 0; widx = 0; sr_cnt = 0; rv_cnt = 0;
            q.push_back('{13'h1FFF, 1'b1, 32'd1});
            for (int i = 0; i < A; i++) q.push_back('{13'd1, 1'b1, words[i]});
            for (int i = 0; i < X; i++) q.push_back('{13'd2, 1'b1, words[A+i]});
            for (int k = 1; k <= R; k++) q.push_back('{13'(4 * k), 1'b0, 32'd0});
            q.push_back('{13'h1FFF, 1'b1, 32'd0});
         end
      end
      prev_psel = bus.PSEL; prev_pen = bus.PENABLE; prev_rdy = bus.PREADY; prev_sr = bus.src_ready;
   end
   task automatic pulse_start();
      @(posedge clk); #1 start = 1;
      @(posedge clk); #1 start = 0;
   endtask
   task automatic wait_done(input string nm);
      bit seen = 0;
      for (int i = 0; i < 8000 && !seen; i++) begin @(negedge clk); seen = done; end
      chk(nm, seen, 1);
   endtask
   initial begin
      bit hit;
      HRESET = 1; start = 0;
      repeat (3) @(posedge clk);
      #1 HRESET = 0;
      @(negedge clk);
      chk("reset_busy", busy, 0); chk("reset_psel", bus.PSEL, 0); chk("reset_res_data", res_data, 0);
      // Run A: zero-wait slave except a 3-cycle stall on the 2nd X write; stray starts while busy.
      stall_at = 6; stall_n = 3;
      pulse_start();
      repeat (40) @(posedge clk);
      #1 start = 1;
      @(posedge clk); #1 start = 0;
      hit = 0;
      for (int i = 0; i < 8000 && !hit; i++) begin
         @(negedge clk);
         hit = bus.PSEL && !bus.PENABLE && bus.PADDR == 13'h1FFF && bus.PWDATA == 32'd0;
      end
      chk("a_en_off_seen", hit, 1);
      @(posedge clk); #1 start = 1;
      @(posedge clk); #1 start = 0;
      repeat (5) @(negedge clk);
      chk("a_transfers", nx, 985); chk("a_results", rv_cnt, 784); chk("a_src_ready", sr_cnt, 199);
      chk("a_stall_len", len6, 4); chk("a_first_res", first_res, 20'hABCDE); chk("a_busy_after", busy, 0);
      chk("a_err", err, 0);
      // Run B: source stalled before the first A word, slave error on read 5.
      stall_at = 0; err_k = 5; src_en = 0;
      pulse_start();
      repeat (20) @(negedge clk);
      chk("b_no_ready", sr_cnt, 0); chk("b_psel_low", bus.PSEL, 0);
      @(posedge clk); #1 src_en = 1;
      wait_done("b_done");
      chk("b_err", err, 1); chk("b_results", rv_cnt, 784); chk("b_transfers", nx, 985);
      // Run C: start clears err, then reset lands mid-ACCESS of an X write.
      err_k = 0; stall_at = 5; stall_n = 20;
      pulse_start();
      @(negedge clk);
      chk("c_err_cleared", err, 0);
      hit = 0;
      for (int i = 0; i < 400 && !hit; i++) begin
         @(negedge clk);
         hit = bus.PENABLE && bus.PADDR == 13'd2;
      end
      chk("c_x_access_seen", hit, 1);
      @(posedge clk); #1 HRESET = 1;
      @(posedge clk); #1 HRESET = 0;
      @(negedge clk);
      chk("c_busy", busy, 0); chk("c_psel", bus.PSEL, 0); chk("c_penable", bus.PENABLE, 0);
      chk("c_paddr", bus.PADDR, 0); chk("c_pwdata", bus.PWDATA, 0);
      // Run D: fresh full run after the reset.
      stall_at = 0;
      pulse_start();
      wait_done("d_done");
      chk("d_transfers", nx, 985); chk("d_results", rv_cnt, 784); chk("d_src_ready", sr_cnt, 199);
      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule
